// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control unit: opcodes, FSM states,
// datapath select encodings, CCR flag positions and the opcode classifier.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_SUB    = 7'b0100000;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;
    localparam logic [2:0] S_BR      = 3'd6;
    localparam logic [2:0] S_TRAP    = 3'd7;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LUI, CL_AUIPC, CL_LOAD, CL_STORE,
        CL_BRANCH, CL_JAL, CL_JALR, CL_BAD
    } instr_class_t;

    localparam logic [1:0] ASEL_RS1    = 2'd0;
    localparam logic [1:0] ASEL_PC     = 2'd1;
    localparam logic [1:0] ASEL_OLD_PC = 2'd2;
    localparam logic [1:0] ASEL_IMM    = 2'd3;

    localparam logic [1:0] BSEL_RS2    = 2'd0;
    localparam logic [1:0] BSEL_IMM    = 2'd1;
    localparam logic [1:0] BSEL_FOUR   = 2'd2;

    localparam logic [1:0] WB_ALU      = 2'd0;
    localparam logic [1:0] WB_MEM      = 2'd1;
    localparam logic [1:0] WB_PC       = 2'd2;

    localparam int CCR_EQ  = 5;
    localparam int CCR_NE  = 4;
    localparam int CCR_LT  = 3;
    localparam int CCR_GE  = 2;
    localparam int CCR_LTU = 1;
    localparam int CCR_GEU = 0;

    function automatic instr_class_t classify(input logic [6:0] opcode);
        instr_class_t cls;
        case (opcode)
            OP_R:      cls = CL_R;
            OP_IMM:    cls = CL_I;
            OP_LUI:    cls = CL_LUI;
            OP_AUIPC:  cls = CL_AUIPC;
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_BRANCH: cls = CL_BRANCH;
            OP_JAL:    cls = CL_JAL;
            OP_JALR:   cls = CL_JALR;
            default:   cls = CL_BAD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/rv_branch_eval.sv
// Branch condition select: picks the CCR flag matching the branch funct3.
// NE is derived from EQ so the ALU's NE bit is never trusted.
module rv_branch_eval
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [5:0] ccr_flags,
    output logic       taken,
    output logic       bad_funct3
);

    logic unused_ne;
    assign unused_ne = ccr_flags[CCR_NE];

    always_comb begin
        taken      = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            3'b000:  taken = ccr_flags[CCR_EQ];
            3'b001:  taken = !ccr_flags[CCR_EQ];
            3'b100:  taken = ccr_flags[CCR_LT];
            3'b101:  taken = ccr_flags[CCR_GE];
            3'b110:  taken = ccr_flags[CCR_LTU];
            3'b111:  taken = ccr_flags[CCR_GEU];
            default: bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences the shared ALU and the single memory
// port through fetch/decode/execute/memory/writeback, with sticky traps.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic [5:0]      ccr_flags,
    input  logic            mem_ready,
    output logic            ir_we,
    output logic            pc_we,
    output logic            pc_src,
    output logic [1:0]      alu_a_sel,
    output logic [1:0]      alu_b_sel,
    output logic [6:0]      alu_opcode,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_addr_sel,
    output logic            rf_we,
    output logic [1:0]      wb_sel,
    output logic            illegal,
    output logic            mem_err,
    output logic [XLEN-1:0] instret
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

    logic [2:0]      state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            taken_reg, taken_next;
    logic            illegal_reg, illegal_next;
    logic            mem_err_reg, mem_err_next;
    logic [XLEN-1:0] instret_reg;
    logic            instret_inc;

    instr_class_t cls;
    logic         rd_nz;
    logic         br_taken, br_bad;
    logic         mem_wait, timed_out;
    logic         unused_fields;

    assign cls           = classify(instr[6:0]);
    assign rd_nz         = |instr[11:7];
    assign unused_fields = ^instr[24:15];

    rv_branch_eval u_branch_eval (
        .funct3     (instr[14:12]),
        .ccr_flags  (ccr_flags),
        .taken      (br_taken),
        .bad_funct3 (br_bad)
    );

    // A cycle waiting on memory that would bring the count to MEM_TIMEOUT traps,
    // unless mem_ready arrives in that same cycle.
    assign mem_wait  = ((state_reg == S_FETCH) || (state_reg == S_MEM)) && !mem_ready;
    assign timed_out = mem_wait && (timer_reg == TIMER_LAST);

    always_comb begin
        state_next   = state_reg;
        taken_next   = taken_reg;
        illegal_next = illegal_reg;
        mem_err_next = mem_err_reg;
        instret_inc  = 1'b0;
        case (state_reg)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    state_next   = S_TRAP;
                    mem_err_next = 1'b1;
                end
            end
            S_DECODE: begin
                if ((cls == CL_BAD) || ((cls == CL_BRANCH) && br_bad)) begin
                    state_next   = S_TRAP;
                    illegal_next = 1'b1;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    CL_LOAD, CL_STORE: state_next = S_MEM;
                    CL_BRANCH: begin
                        state_next = S_BR;
                        taken_next = br_taken;
                    end
                    default: begin
                        state_next  = S_FETCH;
                        instret_inc = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls == CL_STORE) begin
                        state_next  = S_FETCH;
                        instret_inc = 1'b1;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timed_out) begin
                    state_next   = S_TRAP;
                    mem_err_next = 1'b1;
                end
            end
            S_WB, S_BR: begin
                state_next  = S_FETCH;
                instret_inc = 1'b1;
            end
            default: state_next = S_TRAP;
        endcase
    end

    always_comb begin
        timer_next = '0;
        if (mem_wait && (state_next == state_reg)) begin
            timer_next = timer_reg + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            taken_reg   <= 1'b0;
            illegal_reg <= 1'b0;
            mem_err_reg <= 1'b0;
            instret_reg <= '0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            taken_reg   <= taken_next;
            illegal_reg <= illegal_next;
            mem_err_reg <= mem_err_next;
            if (instret_inc) begin
                instret_reg <= instret_reg + XLEN'(1);
            end
        end
    end

    assign illegal = illegal_reg;
    assign mem_err = mem_err_reg;
    assign instret = instret_reg;

    always_comb begin
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        alu_a_sel    = ASEL_RS1;
        alu_b_sel    = BSEL_RS2;
        alu_opcode   = '0;
        alu_funct3   = '0;
        alu_funct7   = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        case (state_reg)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_opcode = OP_IMM;
                alu_a_sel  = ASEL_PC;
                alu_b_sel  = BSEL_FOUR;
                ir_we      = mem_ready;
                pc_we      = mem_ready;
            end
            S_EXEC: begin
                case (cls)
                    CL_R, CL_I: begin
                        alu_opcode = instr[6:0];
                        alu_funct3 = instr[14:12];
                        alu_funct7 = instr[31:25];
                        alu_b_sel  = (cls == CL_I) ? BSEL_IMM : BSEL_RS2;
                        rf_we      = rd_nz;
                    end
                    CL_LUI: begin
                        alu_opcode = instr[6:0];
                        alu_a_sel  = ASEL_IMM;
                        rf_we      = rd_nz;
                    end
                    CL_AUIPC: begin
                        alu_opcode = instr[6:0];
                        alu_a_sel  = ASEL_OLD_PC;
                        alu_b_sel  = BSEL_IMM;
                        rf_we      = rd_nz;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_opcode = OP_IMM;
                        alu_b_sel  = BSEL_IMM;
                    end
                    CL_BRANCH: begin
                        // SUB sets the CCR flags for the comparison
                        alu_opcode = OP_R;
                        alu_funct7 = F7_SUB;
                    end
                    CL_JAL, CL_JALR: begin
                        alu_opcode = OP_IMM;
                        alu_a_sel  = (cls == CL_JAL) ? ASEL_OLD_PC : ASEL_RS1;
                        alu_b_sel  = BSEL_IMM;
                        pc_we      = 1'b1;
                        pc_src     = (cls == CL_JALR);
                        rf_we      = rd_nz;
                        wb_sel     = WB_PC;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                alu_opcode   = OP_IMM;
                alu_b_sel    = BSEL_IMM;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == CL_STORE);
            end
            S_WB: begin
                rf_we  = rd_nz;
                wb_sel = WB_MEM;
            end
            S_BR: begin
                alu_opcode = OP_IMM;
                alu_a_sel  = ASEL_OLD_PC;
                alu_b_sel  = BSEL_IMM;
                pc_we      = taken_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Control FSM for the multicycle RV32I core. It sequences the shared ALU through fetch, decode, execute, memory and writeback. It drives the ALU opcode/funct3/funct7 and operand selects (the same ALU also computes PC+4, addresses and branch targets). It evaluates branches from the ALU CCR flags, handshakes with the single memory port, and raises sticky traps.

Parameters:
MEM_TIMEOUT, 16, cycles mem_req may stay unacknowledged before trap (>=1)
XLEN, 32, datapath width (instr, instret)

Ports:
clk  in  1  core clock
rst_n  in  1  async active-low reset
instr  in  32  instruction register contents
ccr_flags  in  6  ALU CCR {EQ,NE,LT,GE,LTU,GEU}; bit4 (NE) ignored, NE = !EQ
mem_ready  in  1  memory ack for current request
ir_we  out  1  latch instr, old_pc<=pc, on fetch ack
pc_we  out  1  PC write enable
pc_src  out  1  0: ALU result; 1: ALU result & ~1 (JALR)
alu_a_sel  out  2  0 rs1, 1 pc, 2 old_pc, 3 imm
alu_b_sel  out  2  0 rs2, 1 imm, 2 const 4
alu_opcode  out  7  to ALU iflags
alu_funct3  out  3  to ALU
alu_funct7  out  7  to ALU
mem_req  out  1  memory request
mem_we  out  1  store
mem_addr_sel  out  1  0 pc, 1 ALU result
rf_we  out  1  register write (never when rd==0)
wb_sel  out  2  0 ALU result, 1 mem data reg, 2 pc (already PC+4)
illegal  out  1  sticky illegal-instruction trap
mem_err  out  1  sticky memory-timeout trap
instret  out  XLEN  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, instret=0, timeout counter=0, taken=0. IDLE->FETCH unconditionally on the next edge.
- Outputs are decoded combinationally from the registered state and instr. Nothing is asserted outside the states listed below.
- "ADD-forced" means opcode=0010011, f3=000, f7=0.
- FETCH: mem_req=1, addr_sel=0; ALU ADD-forced with a=pc, b=4. On mem_ready: ir_we=1, pc_we=1, pc_src=0, go DECODE. Otherwise stay in FETCH.
- DECODE: no outputs; 1 cycle for the regfile/imm to settle.
  - Class by instr[6:0]: R 0110011, I 0010011, LUI 0110111, AUIPC 0010111, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111.
  - Any other opcode, or BRANCH with funct3 010/011 -> TRAP with illegal=1.
- EXEC, by class (all classes except LOAD/STORE/BRANCH return to FETCH):
  - R/I: opcode/f3/f7 taken from instr; a=rs1; b=rs2 (R) or imm (I); rf_we, wb_sel=0.
  - LUI: opcode from instr, a=imm; rf_we, wb_sel=0.
  - AUIPC: opcode from instr, a=old_pc, b=imm; rf_we, wb_sel=0.
  - LOAD/STORE: ADD-forced, a=rs1, b=imm -> MEM.
  - BRANCH: opcode 0110011, f3=000, f7=0100000, a=rs1, b=rs2. Register taken per funct3: 000 EQ, 001 !EQ, 100 LT, 101 GE, 110 LTU, 111 GEU -> BR.
  - JAL: ADD-forced a=old_pc, b=imm; pc_we, pc_src=0; rf_we, wb_sel=2 in the same cycle (rd receives pre-edge pc = PC+4).
  - JALR: as JAL with a=rs1, pc_src=1.
- MEM: ALU controls held as in EXEC. mem_req=1, addr_sel=1, mem_we=STORE.
  - On ready: STORE -> FETCH; LOAD -> WB.
  - mem_req, mem_we and address stay stable until mem_ready.
- WB: rf_we, wb_sel=1 -> FETCH.
- BR: ADD-forced a=old_pc, b=imm; pc_we=taken, pc_src=0 -> FETCH.
- Timeout: counter increments each FETCH/MEM cycle with mem_ready=0 and clears on ack or state change. When it reaches MEM_TIMEOUT -> TRAP with mem_err=1. A mem_ready arriving in that same cycle wins (no trap).
- TRAP: absorbing; all enables 0; illegal/mem_err held. Only rst_n exits.
- instret increments by 1 on every transition into FETCH from EXEC/MEM/WB/BR; wraps at 2^XLEN-1 -> 0.
- Reset mid-instruction: immediate return to IDLE; no partial write is issued after rst_n deasserts.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR)
  - state enum
  - select encodings (ASEL_*, BSEL_*, WB_*)
  - CCR bit indices
- One sub-module is natural: rv_branch_eval, purely combinational (funct3, ccr_flags -> taken, bad_funct3).

Test Plan:
1. Reset then ADD x3=x1+x2 with mem_ready immediate -> IDLE, FETCH, DECODE, EXEC. EXEC drives opcode 0110011, f3 000, f7 0, rf_we=1, wb_sel=0; instret=1 after 4 cycles.
2. LOAD with mem_ready delayed 3 cycles -> mem_req/addr_sel=1 stable for 4 MEM cycles; WB asserts rf_we with wb_sel=1; instret +1.
3. BEQ with ccr_flags=100101 -> taken=1, BR pc_we=1, a_sel=2. BNE with the same flags -> pc_we=0.
4. JALR at old_pc 0x100 -> EXEC pc_we=1, pc_src=1, rf_we=1, wb_sel=2 in one cycle; then FETCH.
5. Opcode 0001111, then BRANCH with funct3 010 -> TRAP, illegal=1 held, instret unchanged; rst_n pulse clears illegal.
6. MEM_TIMEOUT=4, fetch never acked -> mem_err=1 after 4 waiting cycles. Repeat with ack on the 4th cycle -> no trap.
